// File: rtl/packet_rx_pkg.sv
// Shared definitions for the packet receive path: packet field layout, width and FSM states.
package packet_rx_pkg;

  localparam int PKT_W = 73;

  localparam int VALID_BIT   = 72;
  localparam int DST_Z_LSB   = 69;
  localparam int DST_Y_LSB   = 66;
  localparam int DST_X_LSB   = 63;
  localparam int SRC_Z_LSB   = 60;
  localparam int SRC_Y_LSB   = 57;
  localparam int SRC_X_LSB   = 54;
  localparam int CTX_LSB     = 46;
  localparam int TAG_LSB     = 38;
  localparam int ALG_LSB     = 36;
  localparam int OP_LSB      = 32;
  localparam int PAYLOAD_LSB = 0;

  localparam int COORD_W   = 3;
  localparam int CTX_W     = 8;
  localparam int TAG_W     = 8;
  localparam int ALG_W     = 2;
  localparam int OP_W      = 4;
  localparam int PAYLOAD_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/packet_rx_pkt_fifo.sv
// Power-of-two circular buffer for received packets; head is read combinationally.
module pkt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 73
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/packet_rx.sv
// Receive endpoint: filters packets addressed to this node, buffers them and unpacks the head.
module packet_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int PKT_W      = packet_rx_pkg::PKT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       expected_count,
  input  logic [2:0]       local_z,
  input  logic [2:0]       local_y,
  input  logic [2:0]       local_x,
  input  logic [PKT_W-1:0] Inpacket,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             valid_out,
  output logic [2:0]       dst_z,
  output logic [2:0]       dst_y,
  output logic [2:0]       dst_x,
  output logic [2:0]       src_z,
  output logic [2:0]       src_y,
  output logic [2:0]       src_x,
  output logic [7:0]       contextId,
  output logic [7:0]       tag,
  output logic [1:0]       algtype,
  output logic [3:0]       op,
  output logic [31:0]      payload,
  output logic             done,
  output logic [7:0]       drop_count
);

  import packet_rx_pkg::*;

  logic [1:0]       state;
  logic [7:0]       target;
  logic [7:0]       accepted;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PKT_W-1:0] fifo_head;
  logic [PKT_W-1:0] head;
  logic             offered;
  logic             addr_match;
  logic             accept;
  logic             drop;
  logic             pop;

  assign offered    = Inpacket[VALID_BIT];
  assign addr_match = (Inpacket[DST_X_LSB +: 3*COORD_W] == {local_z, local_y, local_x});
  assign accept     = offered && in_ready && (state == ST_RECV) && addr_match;
  assign drop       = offered && !accept;
  assign in_ready   = !fifo_full;
  assign valid_out  = !fifo_empty;
  assign pop        = valid_out && out_ready;
  assign done       = (state == ST_DONE);

  pkt_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PKT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (Inpacket),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stale storage is masked so every field reads zero while nothing is buffered.
  assign head      = valid_out ? fifo_head : '0;
  assign dst_z     = head[DST_Z_LSB   +: COORD_W];
  assign dst_y     = head[DST_Y_LSB   +: COORD_W];
  assign dst_x     = head[DST_X_LSB   +: COORD_W];
  assign src_z     = head[SRC_Z_LSB   +: COORD_W];
  assign src_y     = head[SRC_Y_LSB   +: COORD_W];
  assign src_x     = head[SRC_X_LSB   +: COORD_W];
  assign contextId = head[CTX_LSB     +: CTX_W];
  assign tag       = head[TAG_LSB     +: TAG_W];
  assign algtype   = head[ALG_LSB     +: ALG_W];
  assign op        = head[OP_LSB      +: OP_W];
  assign payload   = head[PAYLOAD_LSB +: PAYLOAD_W];

  // A start in any state re-arms the epoch; buffered packets survive the restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      target     <= '0;
      accepted   <= '0;
      drop_count <= '0;
    end else if (start) begin
      target     <= expected_count;
      accepted   <= '0;
      drop_count <= '0;
      state      <= (expected_count == 8'd0) ? ST_DRAIN : ST_RECV;
    end else begin
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      case (state)
        ST_RECV: begin
          if (accept) begin
            accepted <= accepted + 8'd1;
            if (accepted + 8'd1 == target) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (fifo_empty) state <= ST_IDLE + ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_rx.sv
// Directed bench for packet_rx: a vector table for the main flows plus hand-written corner sequences.
module tb_packet_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  expected_count;
  logic [8:0]  loc;
  logic [72:0] Inpacket;
  logic        in_ready;
  logic        out_ready;
  logic        valid_out;
  logic [2:0]  dst_z, dst_y, dst_x, src_z, src_y, src_x;
  logic [7:0]  contextId, tag;
  logic [1:0]  algtype;
  logic [3:0]  op;
  logic [31:0] payload;
  logic        done;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  packet_rx #(.FIFO_DEPTH(4), .PKT_W(73)) dut (
    .clk(clk), .rst(rst), .start(start), .expected_count(expected_count),
    .local_z(loc[8:6]), .local_y(loc[5:3]), .local_x(loc[2:0]),
    .Inpacket(Inpacket), .in_ready(in_ready), .out_ready(out_ready),
    .valid_out(valid_out), .dst_z(dst_z), .dst_y(dst_y), .dst_x(dst_x),
    .src_z(src_z), .src_y(src_y), .src_x(src_x), .contextId(contextId),
    .tag(tag), .algtype(algtype), .op(op), .payload(payload),
    .done(done), .drop_count(drop_count)
  );

  typedef struct {
    logic        start;
    logic [7:0]  ecount;
    logic [8:0]  loc;
    logic [72:0] pkt;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_payload;
    logic [7:0]  exp_tag;
    logic [3:0]  exp_op;
    logic [2:0]  exp_src_x;
    logic [7:0]  exp_drop;
    logic        exp_done;
    logic        exp_in_ready;
  } vec_t;

  function automatic logic [72:0] make_pkt(input logic [2:0] dz, input logic [2:0] dy,
                                           input logic [2:0] dx, input logic [2:0] sx,
                                           input logic [7:0] t, input logic [3:0] o,
                                           input logic [31:0] pl);
    return {1'b1, dz, dy, dx, 3'd0, 3'd0, sx, 8'd0, t, 2'd0, o, pl};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    start          = v.start;
    expected_count = v.ecount;
    loc            = v.loc;
    Inpacket       = v.pkt;
    out_ready      = v.out_ready;
    tick();
    start    = 1'b0;
    Inpacket = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    start = 1'b0; expected_count = '0; loc = '0; Inpacket = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  vec_t vecs[14];
  logic [72:0] none;
  logic [8:0]  l100;
  logic        seen;

  initial begin
    none = '0;
    l100 = 9'b001_000_000;
    //           start ecnt  loc   pkt                                          ordy  valid payload  tag op  sx drop done inrdy
    vecs[0]  = '{1'b1, 8'd3, l100, none,                                        1'b1, 1'b0, 32'd0, 0, 0, 0, 0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 8'd3, l100, make_pkt(1,0,0,0,0,0,32'd6),                 1'b1, 1'b1, 32'd6, 0, 0, 0, 0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'd3, l100, make_pkt(1,0,0,0,0,0,32'd5),                 1'b1, 1'b1, 32'd5, 0, 0, 0, 0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'd3, l100, make_pkt(1,0,0,0,0,0,32'd4),                 1'b1, 1'b1, 32'd4, 0, 0, 0, 0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'd3, l100, none,                                        1'b1, 1'b0, 32'd0, 0, 0, 0, 0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'd3, l100, none,                                        1'b1, 1'b0, 32'd0, 0, 0, 0, 0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'd3, l100, none,                                        1'b1, 1'b0, 32'd0, 0, 0, 0, 0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'd1, 9'd0, none,                                        1'b0, 1'b0, 32'd0, 0, 0, 0, 0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 8'd1, 9'd0, make_pkt(1,0,0,0,0,0,32'd9),                 1'b0, 1'b0, 32'd0, 0, 0, 0, 1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'd1, 9'd0, make_pkt(0,0,0,1,8'd1,4'hF,32'h1234),        1'b0, 1'b1, 32'h1234, 1, 15, 1, 1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'd1, 9'd0, none,                                        1'b1, 1'b0, 32'd0, 0, 0, 0, 1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'd1, 9'd0, none,                                        1'b1, 1'b0, 32'd0, 0, 0, 0, 1, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 8'd1, 9'd0, none,                                        1'b1, 1'b0, 32'd0, 0, 0, 0, 1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'd1, 9'd0, make_pkt(0,0,0,0,0,0,32'd7),                 1'b1, 1'b0, 32'd0, 0, 0, 0, 2, 1'b0, 1'b1};

    doReset();
    checkOutput("reset valid_out", 32'(valid_out), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset drop_count", 32'(drop_count), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset payload", payload, 32'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d valid_out", i), 32'(valid_out), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d payload", i), payload, vecs[i].exp_payload);
      checkOutput($sformatf("v%0d tag", i), 32'(tag), 32'(vecs[i].exp_tag));
      checkOutput($sformatf("v%0d op", i), 32'(op), 32'(vecs[i].exp_op));
      checkOutput($sformatf("v%0d src_x", i), 32'(src_x), 32'(vecs[i].exp_src_x));
      checkOutput($sformatf("v%0d drop_count", i), 32'(drop_count), 32'(vecs[i].exp_drop));
      checkOutput($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].exp_done));
      checkOutput($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
    end

    // Backpressure: fill the FIFO, overflow once, then drain in order.
    doReset();
    start = 1'b1; expected_count = 8'd10; tick(); start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Inpacket = make_pkt(0,0,0,0,0,0,32'(10 + i));
      tick();
      Inpacket = '0;
      if (i == 2) checkOutput("full in_ready after 3", 32'(in_ready), 32'd1);
      if (i == 3) checkOutput("full in_ready after 4", 32'(in_ready), 32'd0);
      if (i == 3) checkOutput("full drop after 4", 32'(drop_count), 32'd0);
    end
    checkOutput("full drop after 5", 32'(drop_count), 32'd1);
    checkOutput("full valid_out", 32'(valid_out), 32'd1);
    checkOutput("full head stable", payload, 32'd10);
    tick();
    checkOutput("full head still stable", payload, 32'd10);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain head %0d", i), payload, 32'(10 + i));
      tick();
    end
    checkOutput("drain empty", 32'(valid_out), 32'd0);
    checkOutput("drain in_ready", 32'(in_ready), 32'd1);

    // Misaddressed stream to reach drop_count saturation.
    for (int i = 0; i < 260; i++) begin
      Inpacket = make_pkt(3'd7,0,0,0,0,0,32'd0);
      tick();
    end
    Inpacket = '0;
    checkOutput("drop saturation", 32'(drop_count), 32'd255);

    // Zero-length epoch finishes without packets.
    doReset();
    start = 1'b1; expected_count = 8'd0; tick(); start = 1'b0;
    seen = done;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick();
      seen = done;
    end
    checkOutput("zero count done within 2", 32'(seen), 32'd1);
    checkOutput("zero count no valid", 32'(valid_out), 32'd0);
    tick();
    checkOutput("zero count done pulse", 32'(done), 32'd0);

    // Reset mid-epoch with two packets buffered.
    doReset();
    start = 1'b1; expected_count = 8'd5; tick(); start = 1'b0;
    out_ready = 1'b0;
    Inpacket = make_pkt(0,0,0,0,0,0,32'd21); tick();
    Inpacket = make_pkt(0,0,0,0,0,0,32'd22); tick();
    Inpacket = make_pkt(2,0,0,0,0,0,32'd23); tick();
    Inpacket = '0;
    checkOutput("pre-reset valid_out", 32'(valid_out), 32'd1);
    checkOutput("pre-reset drop_count", 32'(drop_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset valid_out", 32'(valid_out), 32'd0);
    checkOutput("async reset drop_count", 32'(drop_count), 32'd0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("async reset payload", payload, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post-reset valid_out", 32'(valid_out), 32'd0);
    Inpacket = make_pkt(0,0,0,0,0,0,32'd24); tick(); Inpacket = '0;
    checkOutput("post-reset idle drops", 32'(drop_count), 32'd1);
    checkOutput("post-reset idle no accept", 32'(valid_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_rx.md
PACKET_RX -- requirements
Module: packet_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered packets (power of two, 2..16).
REQ-002 Parameter PKT_W, default 73, packet width including the valid bit.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port start, input, 1: single-cycle pulse that arms a receive epoch.
REQ-006 Port expected_count, input, 8: packets to accept per epoch; sampled on start.
REQ-007 Port local_z/local_y/local_x, input, 3 each: this node's coordinate.
REQ-008 Port Inpacket, input, PKT_W: packet from the router.
REQ-009 Packet layout: [72] valid; [71:69] dst_z; [68:66] dst_y; [65:63] dst_x; [62:60] src_z; [59:57] src_y; [56:54] src_x; [53:46] contextId; [45:38] tag; [37:36] algtype; [35:32] op; [31:0] payload.
REQ-010 Port in_ready, output, 1: high when the FIFO is not full.
REQ-011 Port out_ready, input, 1: consumer accepts the head packet.
REQ-012 Port valid_out, output, 1: head packet fields are valid.
REQ-013 Ports dst_z, dst_y, dst_x, src_z, src_y, src_x (3 each), contextId (8), tag (8), algtype (2), op (4), payload (32): outputs carrying the unpacked head packet.
REQ-014 Port done, output, 1: epoch complete.
REQ-015 Port drop_count, output, 8: packets discarded this epoch.

Function
REQ-016 A packet is offered when Inpacket[72] is 1.
REQ-017 An offered packet is accepted when in_ready is 1, the FSM is in RECV, and {dst_z,dst_y,dst_x} equals {local_z,local_y,local_x}.
REQ-018 An offered packet is dropped if it is misaddressed, or if it arrives while full or outside RECV; each drop increments drop_count by 1.
REQ-019 drop_count saturates at 255.
REQ-020 An accepted packet is written to the FIFO in the same cycle; valid_out rises the next cycle if the FIFO was empty.
REQ-021 Output fields are driven combinationally from the FIFO head.
REQ-022 A pop occurs when valid_out and out_ready are both 1.
REQ-023 Output fields hold stable while valid_out=1 and out_ready=0.
REQ-024 A simultaneous push and pop while full is not possible, because in_ready=0.
REQ-025 A simultaneous push and pop at any other occupancy leaves occupancy unchanged.
REQ-026 Read and write pointers wrap modulo FIFO_DEPTH; occupancy is counted in $clog2(FIFO_DEPTH)+1 bits.
REQ-027 The FSM has states IDLE, RECV, DRAIN and DONE.
REQ-028 IDLE -> RECV on start: latch expected_count, clear the accept counter and drop_count.
REQ-029 RECV -> DRAIN when the accept counter reaches the latched count.
REQ-030 A start received in RECV, DRAIN or DONE restarts the epoch (as in IDLE -> RECV); FIFO contents are preserved.
REQ-031 DRAIN -> DONE when the FIFO is empty.
REQ-032 An expected_count of 0 goes IDLE -> DRAIN directly.
REQ-033 done is 1 only in DONE; DONE -> IDLE when start=0 for one cycle after entry (done is a one-cycle pulse).

Reset
REQ-034 On rst, the block shall asynchronously set the FSM to IDLE and clear the FIFO pointers, occupancy, accept counter and drop_count.
REQ-035 During and after reset the outputs shall read valid_out=0, done=0, drop_count=0 and in_ready=1; all field outputs read 0 while empty.
REQ-036 A reset mid-epoch discards buffered packets without asserting valid_out.

Structure
REQ-037 A shared package holds the field bit-offset and width constants, PKT_W, and the FSM state enumeration.
REQ-038 The same package is used by the packet-builder top.
REQ-039 A single sub-module, pkt_fifo (parameterised depth/width, push/pop/full/empty), holds the storage.
REQ-040 Unpacking and filtering live in packet_rx.

Verification
REQ-041 Local (1,0,0), expected_count=3, three packets dst (1,0,0) with payload 6,5,4 and out_ready=1 -> valid_out for 3 cycles with payload 6,5,4 in order, then done=1 one cycle after FIFO empty.
REQ-042 Local (0,0,0), packet dst (1,0,0) in RECV -> no valid_out, drop_count=1.
REQ-043 out_ready=0, five matching packets, FIFO_DEPTH=4 -> in_ready=0 after the 4th, the 5th is dropped (drop_count=1), and the head payload holds stable.
REQ-044 expected_count=0 with start -> done=1 within 2 cycles, with no packets.
REQ-045 rst asserted with 2 packets buffered -> valid_out=0 immediately, drop_count=0, FSM IDLE.
REQ-046 Packet with tag=1, op=4'b1111, src_x=1, contextId=0 -> outputs tag=1, op=15, src_x=1 exactly as unpacked.
